// File: rtl/jtkiwi_obj_pkg.sv
// Shared definitions for the object line scanner: FSM states, LUT word
// selection and the bit layout of the two attribute words.
package jtkiwi_obj_pkg;

    typedef enum logic [2:0] {
        IDLE,
        YCHK,
        ATTR_A,
        ATTR_B,
        ISSUE,
        DONE
    } state_t;

    // word_sel bit of lut_addr
    localparam logic WORD_A = 1'b1;
    localparam logic WORD_B = 1'b0;

    // Word A: {pal[4:0], code[15:14], xpos[8:0]}
    localparam int A_PAL_LSB    = 11;
    localparam int A_CODEHI_LSB = 9;
    localparam int A_XPOS_LSB   = 0;

    // Word B: {hflip, vflip, code[13:0]}
    localparam int B_HFLIP_BIT  = 15;
    localparam int B_VFLIP_BIT  = 14;
    localparam int B_CODE_LSB   = 0;

endpackage

// File: rtl/jtkiwi_objscan_match.sv
// Combinational Y test: does the object at y_data cover the line about to be
// drawn, and which row of the object is it.
module jtkiwi_objscan_match
    import jtkiwi_obj_pkg::*;
#(
    parameter int HW = 4
) (
    input  logic          flip_i,
    input  logic [8:0]    vdump_i,
    input  logic [7:0]    y_data_i,
    output logic          match_o,
    output logic [HW-1:0] ysub_o
);

    logic [8:0] vf;
    logic [8:0] ydiff;
    logic       unused_vf_msb;

    // Next line (flipped when needed) minus object Y; a borrow or any bit at or
    // above HW means the line lies outside the object.
    always_comb begin
        vf      = {9{flip_i}} ^ (vdump_i - 9'd1);
        ydiff   = {1'b0, vf[7:0]} - {1'b0, y_data_i};
        match_o = (ydiff[8:HW] == '0);
        ysub_o  = ydiff[HW-1:0];
    end

    // Only the low byte of the line number takes part in the comparison
    assign unused_vf_msb = vf[8];

endmodule

// File: rtl/jtkiwi_objscan.sv
// Object line scanner: walks the object table from the top index down,
// fetches both attribute words of every object on the next line and hands
// them to the draw engine through a draw/busy handshake.
module jtkiwi_objscan
    import jtkiwi_obj_pkg::*;
#(
    parameter int OBJW    = 9,
    parameter int HW      = 4,
    parameter int LIMIT   = 0,
    parameter int LUT_LAT = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            lut_cen_i,
    input  logic            hs_i,
    input  logic            vb_i,
    input  logic            flip_i,
    input  logic            page_i,
    input  logic [8:0]      vdump_i,
    output logic [OBJW+2:0] lut_addr_o,
    input  logic [15:0]     lut_data_i,
    output logic [OBJW-1:0] y_addr_o,
    input  logic [7:0]      y_data_i,
    output logic            dr_draw_o,
    input  logic            dr_busy_i,
    output logic [12:0]     dr_code_o,
    output logic [4:0]      dr_pal_o,
    output logic            dr_hflip_o,
    output logic            dr_vflip_o,
    output logic [8:0]      dr_xpos_o,
    output logic [HW-1:0]   dr_ysub_o,
    output logic            ovf_o,
    output logic            done_o
);

    localparam logic [OBJW-1:0] OBJ_TOP  = {OBJW{1'b1}};
    localparam logic [OBJW:0]   LIMIT_W  = (OBJW+1)'(LIMIT);
    localparam logic [1:0]      LAT_LAST = 2'(LUT_LAT - 1);

    state_t          state_q;
    logic [OBJW-1:0] objcnt_q;
    logic [OBJW:0]   draws_q;
    logic [1:0]      wait_q;
    logic [HW-1:0]   ysub_q;
    logic [4:0]      pal_q;
    logic [8:0]      xpos_q;
    logic [12:0]     code_q;
    logic            hflip_q;
    logic            vflip_q;
    logic            dr_draw_q;
    logic [12:0]     dr_code_q;
    logic [4:0]      dr_pal_q;
    logic            dr_hflip_q;
    logic            dr_vflip_q;
    logic [8:0]      dr_xpos_q;
    logic [HW-1:0]   dr_ysub_q;
    logic            ovf_q;
    logic            done_q;

    logic            match;
    logic [HW-1:0]   ysub;
    logic            limit_hit;
    logic            last_obj;
    logic            word_sel;

    jtkiwi_objscan_match #(.HW(HW)) u_match (
        .flip_i   (flip_i),
        .vdump_i  (vdump_i),
        .y_data_i (y_data_i),
        .match_o  (match),
        .ysub_o   (ysub)
    );

    assign limit_hit = (LIMIT != 0) && (draws_q == LIMIT_W);
    assign last_obj  = (objcnt_q == '0);
    assign word_sel  = (state_q == ATTR_A) ? WORD_A : WORD_B;

    assign lut_addr_o = {page_i, 1'b0, word_sel, objcnt_q};
    assign y_addr_o   = objcnt_q;
    assign dr_draw_o  = dr_draw_q;
    assign dr_code_o  = dr_code_q;
    assign dr_pal_o   = dr_pal_q;
    assign dr_hflip_o = dr_hflip_q;
    assign dr_vflip_o = dr_vflip_q;
    assign dr_xpos_o  = dr_xpos_q;
    assign dr_ysub_o  = dr_ysub_q;
    assign ovf_o      = ovf_q;
    assign done_o     = done_q;

    // Scan FSM; hs/vb restart the line and take priority over any pending issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            objcnt_q   <= OBJ_TOP;
            draws_q    <= '0;
            wait_q     <= '0;
            ysub_q     <= '0;
            pal_q      <= '0;
            xpos_q     <= '0;
            code_q     <= '0;
            hflip_q    <= 1'b0;
            vflip_q    <= 1'b0;
            dr_draw_q  <= 1'b0;
            dr_code_q  <= '0;
            dr_pal_q   <= '0;
            dr_hflip_q <= 1'b0;
            dr_vflip_q <= 1'b0;
            dr_xpos_q  <= '0;
            dr_ysub_q  <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else if (hs_i || vb_i) begin
            state_q   <= YCHK;
            objcnt_q  <= OBJ_TOP;
            draws_q   <= '0;
            wait_q    <= '0;
            dr_draw_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            dr_draw_q <= 1'b0;
            case (state_q)
                YCHK: if (lut_cen_i) begin
                    ysub_q <= ysub;
                    wait_q <= '0;
                    if (match && limit_hit) begin
                        ovf_q   <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (match) begin
                        state_q <= ATTR_A;
                    end else if (last_obj) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        objcnt_q <= objcnt_q - 1'b1;
                    end
                end
                ATTR_A: if (lut_cen_i) begin
                    if (wait_q == LAT_LAST) begin
                        pal_q   <= lut_data_i[A_PAL_LSB +: 5];
                        xpos_q  <= lut_data_i[A_XPOS_LSB +: 9];
                        wait_q  <= '0;
                        state_q <= ATTR_B;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                ATTR_B: if (lut_cen_i) begin
                    if (wait_q == LAT_LAST) begin
                        hflip_q <= lut_data_i[B_HFLIP_BIT];
                        vflip_q <= lut_data_i[B_VFLIP_BIT];
                        code_q  <= lut_data_i[B_CODE_LSB +: 13];
                        wait_q  <= '0;
                        state_q <= ISSUE;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                // Handshake runs at full clock rate, independent of lut_cen
                ISSUE: if (!dr_busy_i) begin
                    dr_draw_q  <= 1'b1;
                    dr_code_q  <= code_q;
                    dr_pal_q   <= pal_q;
                    dr_hflip_q <= hflip_q ^ flip_i;
                    dr_vflip_q <= vflip_q;
                    dr_xpos_q  <= xpos_q;
                    dr_ysub_q  <= ~ysub_q;
                    draws_q    <= draws_q + 1'b1;
                    if (last_obj) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        objcnt_q <= objcnt_q - 1'b1;
                        state_q  <= YCHK;
                    end
                end
                IDLE, DONE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jtkiwi_objscan.sv
// Bench for the object line scanner: two instances (default-like and
// HW=5/LUT_LAT=2), behavioural Y and attribute memories, and a scoreboard of
// expected draw requests filled when a line is set up.
module tb_jtkiwi_objscan;

    localparam int OBJW = 5;
    localparam int NOBJ = 1 << OBJW;

    typedef struct {
        logic [12:0] code;
        logic [4:0]  pal;
        logic        hflip;
        logic        vflip;
        logic [8:0]  xpos;
        logic [4:0]  ysub;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic lut_cen = 1'b1;
    logic flip = 1'b0;
    logic page = 1'b0;
    logic [8:0] vdump = 9'h21;
    logic cen_rand = 1'b0;

    logic [1:0]         hs_w = 2'b00;
    logic [1:0]         vb_w = 2'b10;
    logic [1:0]         busy_w = 2'b00;
    logic [1:0][7:0]    lut_addr_w;
    logic [1:0][15:0]   lut_data_w;
    logic [1:0][4:0]    y_addr_w;
    logic [1:0][7:0]    y_data_w;
    logic [1:0]         draw_w, hfl_w, vfl_w, ovf_w, done_w;
    logic [1:0][12:0]   code_w;
    logic [1:0][4:0]    pal_w;
    logic [1:0][8:0]    xpos_w;
    logic [1:0][4:0]    ysub_w;
    logic [15:0]        pipe_b;

    logic [7:0]  ymem [NOBJ];
    logic [15:0] lutmem [256];

    exp_t q0[$];
    exp_t q1[$];
    exp_t last_exp [2];
    int   draw_cnt [2];
    logic [4:0] obs_ysub [2];
    logic [1:0] prev_draw = 2'b00;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    jtkiwi_objscan #(.OBJW(OBJW), .HW(4), .LIMIT(2), .LUT_LAT(1)) u_a (
        .clk(clk), .rst_n(rst_n), .lut_cen_i(lut_cen), .hs_i(hs_w[0]), .vb_i(vb_w[0]),
        .flip_i(flip), .page_i(page), .vdump_i(vdump),
        .lut_addr_o(lut_addr_w[0]), .lut_data_i(lut_data_w[0]),
        .y_addr_o(y_addr_w[0]), .y_data_i(y_data_w[0]),
        .dr_draw_o(draw_w[0]), .dr_busy_i(busy_w[0]), .dr_code_o(code_w[0]),
        .dr_pal_o(pal_w[0]), .dr_hflip_o(hfl_w[0]), .dr_vflip_o(vfl_w[0]),
        .dr_xpos_o(xpos_w[0]), .dr_ysub_o(ysub_w[0][3:0]),
        .ovf_o(ovf_w[0]), .done_o(done_w[0])
    );

    jtkiwi_objscan #(.OBJW(OBJW), .HW(5), .LIMIT(0), .LUT_LAT(2)) u_b (
        .clk(clk), .rst_n(rst_n), .lut_cen_i(lut_cen), .hs_i(hs_w[1]), .vb_i(vb_w[1]),
        .flip_i(flip), .page_i(page), .vdump_i(vdump),
        .lut_addr_o(lut_addr_w[1]), .lut_data_i(lut_data_w[1]),
        .y_addr_o(y_addr_w[1]), .y_data_i(y_data_w[1]),
        .dr_draw_o(draw_w[1]), .dr_busy_i(busy_w[1]), .dr_code_o(code_w[1]),
        .dr_pal_o(pal_w[1]), .dr_hflip_o(hfl_w[1]), .dr_vflip_o(vfl_w[1]),
        .dr_xpos_o(xpos_w[1]), .dr_ysub_o(ysub_w[1]),
        .ovf_o(ovf_w[1]), .done_o(done_w[1])
    );

    assign ysub_w[0][4]  = 1'b0;
    assign y_data_w[0]   = ymem[y_addr_w[0]];
    assign y_data_w[1]   = ymem[y_addr_w[1]];
    assign lut_data_w[0] = lutmem[lut_addr_w[0]];
    assign lut_data_w[1] = pipe_b;

    // Instance b sees a LUT with one extra registered stage
    always @(posedge clk) if (lut_cen) pipe_b <= lutmem[lut_addr_w[1]];

    always @(negedge clk) lut_cen = cen_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Draw monitor: pops the scoreboard on every draw request
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (draw_w[i]) begin
                exp_t e;
                bit have;
                have = 1'b0;
                draw_cnt[i]++;
                obs_ysub[i] = ysub_w[i];
                $display("draw inst=%0d code=%h pal=%h hf=%b vf=%b x=%h ysub=%h",
                         i, code_w[i], pal_w[i], hfl_w[i], vfl_w[i], xpos_w[i], ysub_w[i]);
                if (prev_draw[i]) chk("draw_gap", 32'(prev_draw[i]), 32'(0));
                if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
                if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
                if (!have) begin
                    chk("draw_unexpected", 32'(draw_w[i]), 32'(0));
                end else begin
                    last_exp[i] = e;
                    chk("draw_code",  32'(code_w[i]), 32'(e.code));
                    chk("draw_pal",   32'(pal_w[i]),  32'(e.pal));
                    chk("draw_hflip", 32'(hfl_w[i]),  32'(e.hflip));
                    chk("draw_vflip", 32'(vfl_w[i]),  32'(e.vflip));
                    chk("draw_xpos",  32'(xpos_w[i]), 32'(e.xpos));
                    chk("draw_ysub",  32'(ysub_w[i]), 32'(e.ysub));
                end
            end
        end
        prev_draw = draw_w;
    end

    task automatic clear_y();
        for (int k = 0; k < NOBJ; k++) ymem[k] = 8'hFF;
    endtask

    // Expected draws for the current memories: an object covers line vf when
    // 0 <= vf - y < 2**hw, walking from the top index down
    task automatic plan_line(input int sel, input int hw, input int limit, output bit exp_ovf);
        int nmatch;
        int vf8;
        int row;
        logic [8:0] vf9;
        logic [15:0] wa, wb;
        exp_t e;
        nmatch = 0;
        exp_ovf = 1'b0;
        vf9 = vdump - 9'd1;
        if (flip) vf9 = ~vf9;
        vf8 = int'(vf9[7:0]);
        for (int k = NOBJ - 1; k >= 0; k--) begin
            row = vf8 - int'(ymem[k]);
            if (row >= 0 && row < (1 << hw)) begin
                if (limit != 0 && nmatch >= limit) begin
                    exp_ovf = 1'b1;
                    break;
                end
                wa = lutmem[{page, 1'b0, 1'b1, 5'(k)}];
                wb = lutmem[{page, 1'b0, 1'b0, 5'(k)}];
                e.code  = wb[12:0];
                e.pal   = wa[15:11];
                e.xpos  = wa[8:0];
                e.hflip = wb[15] ^ flip;
                e.vflip = wb[14];
                e.ysub  = 5'(~row) & 5'((1 << hw) - 1);
                if (sel == 0) q0.push_back(e); else q1.push_back(e);
                nmatch++;
            end
        end
    endtask

    task automatic pulse_hs(input int sel);
        @(negedge clk);
        hs_w[sel] = 1'b1;
        vb_w[sel] = 1'b0;
        @(negedge clk);
        hs_w[sel] = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int n;
        n = 0;
        while (!done_w[sel] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("line_done", 32'(done_w[sel]), 32'(1));
    endtask

    task automatic run_line(input int sel, input int hw, input int limit);
        bit eo;
        plan_line(sel, hw, limit, eo);
        pulse_hs(sel);
        wait_done(sel);
        @(negedge clk);
        chk("line_ovf", 32'(ovf_w[sel]), 32'(eo));
        chk("line_left", (sel == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        int held_draws;
        draw_cnt[0] = 0;
        draw_cnt[1] = 0;
        for (int k = 0; k < 256; k++) lutmem[k] = 16'($urandom);
        clear_y();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_draw", 32'(draw_w[0]), 32'(0));
        chk("rst_out",  32'({code_w[0], pal_w[0], xpos_w[0], ysub_w[0], ovf_w[0], done_w[0]}), 32'(0));
        chk("rst_yaddr", 32'(y_addr_w[0]), 32'(NOBJ - 1));
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_yaddr", 32'(y_addr_w[0]), 32'(NOBJ - 1));
        chk("idle_done",  32'(done_w[0]), 32'(0));

        // 1: single match at the top index
        flip = 1'b0; page = 1'b0; vdump = 9'h021;
        clear_y(); ymem[NOBJ-1] = 8'h20;
        d0 = draw_cnt[0];
        run_line(0, 4, 2);
        chk("t1_ndraw", 32'(draw_cnt[0] - d0), 32'(1));
        chk("t1_ysub",  32'(obs_ysub[0]), 32'(5'h0F));

        // 2: flipped screen, second page
        flip = 1'b1; page = 1'b1;
        clear_y(); ymem[12] = 8'hD0;
        d0 = draw_cnt[0];
        run_line(0, 4, 2);
        chk("t2_ndraw", 32'(draw_cnt[0] - d0), 32'(1));
        chk("t2_ysub",  32'(obs_ysub[0]), 32'(0));

        // 3: per-line limit with five matches and an irregular lut_cen
        flip = 1'b0; page = 1'b0;
        clear_y();
        ymem[30] = 8'h20; ymem[25] = 8'h1A; ymem[20] = 8'h11; ymem[10] = 8'h18; ymem[3] = 8'h20;
        cen_rand = 1'b1;
        d0 = draw_cnt[0];
        run_line(0, 4, 2);
        cen_rand = 1'b0;
        chk("t3_ndraw", 32'(draw_cnt[0] - d0), 32'(2));
        chk("t3_ovf",   32'(ovf_w[0]), 32'(1));
        @(negedge clk); hs_w[0] = 1'b1;
        @(negedge clk); hs_w[0] = 1'b0; vb_w[0] = 1'b1;
        chk("t3_ovf_clr",  32'(ovf_w[0]), 32'(0));
        chk("t3_done_clr", 32'(done_w[0]), 32'(0));

        // 4: engine busy while the request is pending
        begin
            bit eo;
            clear_y(); ymem[NOBJ-1] = 8'h20;
            plan_line(0, 4, 2, eo);
            busy_w[0] = 1'b1;
            d0 = draw_cnt[0];
            pulse_hs(0);
            repeat (12) @(negedge clk);
            held_draws = draw_cnt[0] - d0;
            chk("t4_hold_draw", 32'(held_draws), 32'(0));
            chk("t4_hold_code", 32'(code_w[0]), 32'(last_exp[0].code));
            chk("t4_hold_xpos", 32'(xpos_w[0]), 32'(last_exp[0].xpos));
            busy_w[0] = 1'b0;
            @(negedge clk);
            chk("t4_draw_after_busy", 32'(draw_w[0]), 32'(1));
            wait_done(0);
            @(negedge clk);
            chk("t4_left", 32'(q0.size()), 32'(0));
        end

        // 5: hs during ATTR_B aborts the object, vb holds the scanner
        clear_y(); ymem[NOBJ-1] = 8'h20;
        d0 = draw_cnt[0];
        pulse_hs(0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); hs_w[0] = 1'b1;
        @(negedge clk); hs_w[0] = 1'b0; vb_w[0] = 1'b1;
        chk("t5_yaddr", 32'(y_addr_w[0]), 32'(NOBJ - 1));
        chk("t5_done",  32'(done_w[0]), 32'(0));
        repeat (8) @(negedge clk);
        chk("t5_vb_yaddr", 32'(y_addr_w[0]), 32'(NOBJ - 1));
        chk("t5_vb_lut",   32'(lut_addr_w[0]), 32'({1'b0, 1'b0, 1'b0, 5'h1F}));
        chk("t5_nodraw",   32'(draw_cnt[0] - d0), 32'(0));
        run_line(0, 4, 2);
        chk("t5_ndraw", 32'(draw_cnt[0] - d0), 32'(1));

        // 6: 32-line objects, two-strobe LUT, then reset mid-scan
        flip = 1'b0; page = 1'b0; vdump = 9'h030;
        clear_y(); ymem[20] = 8'h10;
        d0 = draw_cnt[1];
        run_line(1, 5, 0);
        chk("t6_ndraw", 32'(draw_cnt[1] - d0), 32'(1));
        chk("t6_ysub",  32'(obs_ysub[1]), 32'(0));
        pulse_hs(1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_b", 32'({draw_w[1], code_w[1], pal_w[1], hfl_w[1], vfl_w[1], ovf_w[1], done_w[1]}), 32'(0));
        chk("t6_rst_b2", 32'({xpos_w[1], ysub_w[1]}), 32'(0));
        chk("t6_rst_a", 32'({draw_w[0], code_w[0], pal_w[0], ovf_w[0], done_w[0]}), 32'(0));
        chk("t6_rst_yaddr", 32'(y_addr_w[1]), 32'(NOBJ - 1));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
